// File: rtl/dense_mem_pkg.sv
// Shared defaults and FSM state type for the dense-layer-2 weight memory.
package dense_mem_pkg;

    localparam int unsigned NUM_BANKS_DEF = 16;
    localparam int unsigned ADDR_W_DEF    = 8;
    localparam int unsigned DATA_W_DEF    = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

endpackage

// File: rtl/dense_l2_wload.sv
// Streams N_WORDS weight words into NUM_BANKS interleaved banks:
// word n lands in bank n mod NUM_BANKS at address n / NUM_BANKS.
module dense_l2_wload
    import dense_mem_pkg::*;
#(
    parameter int unsigned NUM_BANKS = NUM_BANKS_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned N_WORDS   = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_W-1:0]    s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [NUM_BANKS-1:0] wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned BANK_W = $clog2(NUM_BANKS);
    localparam int unsigned CNT_W  = $clog2(N_WORDS + 1);
    localparam int unsigned IDX_W  = BANK_W + ADDR_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_WORDS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             final_word;

    // Counter low bits pick the bank, upper bits the address.
    assign idx        = IDX_W'(cnt);
    assign accept     = s_valid & s_ready;
    assign final_word = (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            s_ready <= 1'b0;
            wr_en   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            wr_en <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        cnt     <= '0;
                        err     <= 1'b0;
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wr_en   <= NUM_BANKS'(1) << idx[BANK_W-1:0];
                        wr_addr <= idx[IDX_W-1:BANK_W];
                        wr_data <= s_data;
                        cnt     <= cnt + 1'b1;
                        // Early s_last or a missing s_last on the final word is a framing error.
                        if (final_word || s_last) begin
                            state   <= DONE;
                            s_ready <= 1'b0;
                            done    <= 1'b1;
                            err     <= ~(final_word & s_last);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
